pc_call_stack: RTL and testbench
================================

// Module: pc_call_stack
// PURPOSE
//  Hack-style program counter with a hardware return-address stack (call/ret).
//  Register-level stage built on the Module 3 Bit/Register primitives.
//  Its out drives the instruction-memory address. It consumes load/inc/jump
//  controls and the jump target from the CPU control path.
// PARAMETERS
//  WIDTH        16  PC and stack entry width in bits
//  STACK_DEPTH  8   number of return-address entries (power of 2, >=2)
//  SPW          3   stack-pointer width = $clog2(STACK_DEPTH); count port is SPW+1
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          async active-low reset
//  reset       in   1          sync reset of PC (Hack semantics)
//  load        in   1          PC <= in
//  inc         in   1          PC <= PC+1
//  call        in   1          push PC+1, then PC <= in
//  ret         in   1          PC <= popped address
//  in          in   WIDTH      jump/call target
//  out         out  WIDTH      current PC
//  depth       out  SPW+1      entries on the stack (0..STACK_DEPTH)
//  full        out  1          depth == STACK_DEPTH
//  empty       out  1          depth == 0
//  err         out  1          stack fault (call when full / ret when empty)
// BEHAVIOUR
//  - rst_n low (async): out=0, depth=0, full=0, empty=1, err=0. Stack RAM is not cleared.
//  - All other updates occur on posedge clk. Every output is registered,
//    except full/empty, which are decoded from depth.
//  - Per-cycle priority (highest wins; lower inputs are ignored that cycle):
//    reset > ret > call > load > inc > hold.
//  - reset: out=0, depth=0. err clears only in sticky mode (see CONFIGURATION).
//  - ret with depth>0:
//    - out <= stack[depth-1]; depth <= depth-1.
//  - ret with depth==0:
//    - out holds and depth holds.
//    - err fault raised.
//  - call with depth<STACK_DEPTH:
//    - stack[depth] <= out+1 (mod 2^WIDTH); out <= in; depth <= depth+1.
//  - call with depth==STACK_DEPTH:
//    - no push, no jump; out holds.
//    - err fault raised.
//  - load: out <= in.
//  - inc: out <= out+1, wrapping from 2^WIDTH-1 to 0 with no flag.
//  - Latency:
//    - All effects are visible on out the cycle after the edge.
//    - A ret on the cycle after a call returns the just-pushed value. No bypass
//      is needed, because the push completes at the edge.
//  - Every op is a single cycle; there is no FSM beyond the depth counter.
//    The stack is a register array indexed by depth.
//  - Wrap-around: out+1 for the pushed address wraps modulo 2^WIDTH.
//  - rst_n asserted mid-operation overrides everything immediately.
// CONFIGURATION
//  ERR_STICKY_EN
//   - undefined: err is a one-cycle pulse in the cycle after the faulting edge.
//     It is 0 otherwise.
//   - defined: err sets on a fault and stays 1 until reset or rst_n.
//     A later valid op does not clear it.
// TESTING
//  1. rst_n=0 mid-count (out=5) -> out=0, depth=0, empty=1 immediately,
//     before any clock edge.
//  2. load in=0x0100, then inc x3 -> out=0x0103.
//     Then inc from 0xFFFF -> 0x0000.
//  3. out=0x0010, call in=0x0200 -> out=0x0200, depth=1.
//     Then ret -> out=0x0011, depth=0, empty=1.
//  4. Fill the stack:
//     - 8 calls fill it, depth=8, full=1.
//     - A 9th call in=0x0300 -> out unchanged, depth=8, err=1 (pulse, or held
//       with ERR_STICKY_EN).
//  5. Stack underflow:
//     - ret with depth=0 -> out unchanged, err=1.
//     - Next cycle: err=0 without the macro; err=1 with it, until reset=1
//       clears it.
//  6. Priority:
//     - reset+ret+load same cycle -> out=0, depth=0.
//     - ret+call+inc same cycle (depth=2) -> pop only, depth=1.

Source files
------------

// File: rtl/pc_call_stack_if.sv
// ---------------------------------------------------------------------------
// pc_call_stack_if
//   Control/status bundle between the CPU control path and the program
//   counter. The control path drives reset/load/inc/call/ret and the target
//   address. The PC drives back the current address and the stack status.
//   master : control path side (drives controls, observes PC and status)
//   slave  : pc_call_stack side
// ---------------------------------------------------------------------------
interface pc_call_stack_if #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8,
    parameter int SPW         = $clog2(STACK_DEPTH)
);
    // Controls from the CPU control path
    logic             reset;   // synchronous PC reset (Hack semantics)
    logic             load;    // PC <= in
    logic             inc;     // PC <= PC + 1
    logic             call;    // push PC + 1, then PC <= in
    logic             ret;     // PC <= popped return address
    logic [WIDTH-1:0] in;      // jump / call target

    // Status back to the control path and instruction memory
    logic [WIDTH-1:0] out;     // current PC, drives the instruction-memory address
    logic [SPW:0]     depth;   // entries on the return stack, 0..STACK_DEPTH
    logic             full;    // depth == STACK_DEPTH
    logic             empty;   // depth == 0
    logic             err;     // stack fault (call when full / ret when empty)

    modport master (
        output reset, load, inc, call, ret, in,
        input  out, depth, full, empty, err
    );

    modport slave (
        input  reset, load, inc, call, ret, in,
        output out, depth, full, empty, err
    );
endinterface : pc_call_stack_if

// File: rtl/pc_call_stack.sv
// ---------------------------------------------------------------------------
// pc_call_stack
//   Hack-style program counter with a hardware return-address stack.
//   One operation per cycle. Priority, highest first:
//     reset > ret > call > load > inc > hold
//   call pushes PC+1 and jumps to in. ret pops into the PC. A call when the
//   stack is full, or a ret when it is empty, leaves PC and depth unchanged
//   and raises err.
//
//   Optional feature macro: ERR_STICKY_EN
//     undefined : err is a one-cycle pulse after the faulting edge.
//     defined   : err holds 1 from the first fault until reset or rst_n.
//
//   The stack is a register array indexed by depth and is not cleared by
//   either reset. Entries above depth are never read.
// ---------------------------------------------------------------------------
module pc_call_stack #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8,    // power of 2, >= 2
    parameter int SPW         = $clog2(STACK_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_call_stack_if.slave bus
);

    // Decoded operation for this cycle after priority resolution
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET,
        OP_RESET
    } op_e;

    localparam logic [SPW:0] DEPTH_MAX = (SPW + 1)'(STACK_DEPTH);

    // Architectural state
    logic [WIDTH-1:0] out_q, out_d;
    logic [SPW:0]     depth_q, depth_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    // Per-cycle control
    op_e              op;
    logic             fault;
    logic             push_en;
    logic [WIDTH-1:0] out_inc;
    logic [SPW-1:0]   wr_idx;
    logic [SPW-1:0]   rd_idx;

    // The return address is the next sequential PC. The addition wraps
    // modulo 2^WIDTH, so a call from the last address pushes 0.
    assign out_inc = out_q + WIDTH'(1);

    // The push slot is the current depth. The pop slot is the entry below it.
    // When the stack is full, depth's low bits are zero and rd_idx wraps to
    // the top entry. A push is never attempted in that case.
    assign wr_idx = depth_q[SPW-1:0];
    assign rd_idx = depth_q[SPW-1:0] - SPW'(1);

    // Resolve simultaneous controls into a single operation
    always_comb begin
        op = OP_HOLD;
        if (bus.reset) begin
            op = OP_RESET;
        end else if (bus.ret) begin
            op = OP_RET;
        end else if (bus.call) begin
            op = OP_CALL;
        end else if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.inc) begin
            op = OP_INC;
        end
    end

    // Next-state for PC, depth and err, plus the stack write enable
    always_comb begin
        // NOTE: every output of this block gets a default before the case.
        // Otherwise a path that skips an assignment would infer a latch.
        out_d   = out_q;
        depth_d = depth_q;
        push_en = 1'b0;
        fault   = 1'b0;

        unique case (op)
            OP_RESET: begin
                out_d   = '0;
                depth_d = '0;
            end
            OP_RET: begin
                if (depth_q != '0) begin
                    out_d   = stack_q[rd_idx];
                    depth_d = depth_q - (SPW + 1)'(1);
                end else begin
                    fault = 1'b1;
                end
            end
            OP_CALL: begin
                if (depth_q != DEPTH_MAX) begin
                    push_en = 1'b1;
                    out_d   = bus.in;
                    depth_d = depth_q + (SPW + 1)'(1);
                end else begin
                    fault = 1'b1;
                end
            end
            OP_LOAD: begin
                out_d = bus.in;
            end
            OP_INC: begin
                out_d = out_inc;
            end
            default: begin
                // OP_HOLD: keep everything
            end
        endcase

`ifdef ERR_STICKY_EN
        // Sticky: a fault sets err, and only a synchronous reset clears it
        err_d = (op == OP_RESET) ? 1'b0 : (err_q | fault);
`else
        // Pulse: err reflects only the fault from the previous edge
        err_d = fault;
`endif
    end

    // PC, depth and err registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample pre-edge values, whatever order the statements appear in.
        if (!rst_n) begin
            out_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage, written only on a successful call
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset. Entries are only read below
        // depth, and depth always clears, so stale contents are never seen.
        // Leaving the array out of reset lets it map to plain storage.
        if (push_en) begin
            stack_q[wr_idx] <= out_inc;
        end
    end

    // Registered outputs. full/empty are decoded from the depth register.
    assign bus.out   = out_q;
    assign bus.depth = depth_q;
    assign bus.err   = err_q;
    assign bus.full  = (depth_q == DEPTH_MAX);
    assign bus.empty = (depth_q == '0);

endmodule : pc_call_stack

// File: tb/tb_pc_call_stack.sv
// ---------------------------------------------------------------------------
// tb_pc_call_stack
//   Table-driven bench for pc_call_stack. Each record holds one cycle of
//   controls plus the expected PC, depth and err after that edge. err has
//   separate columns for pulse mode and sticky mode (ERR_STICKY_EN).
//   Expected values are queued when a record is driven. They are popped and
//   compared one time unit after the edge. The asynchronous reset is
//   exercised by a hand-written sequence between edges.
// ---------------------------------------------------------------------------
module tb_pc_call_stack;

    localparam int WIDTH       = 16;
    localparam int STACK_DEPTH = 8;
    localparam int SPW         = 3;

`ifdef ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_call_stack_if #(
        .WIDTH      (WIDTH),
        .STACK_DEPTH(STACK_DEPTH),
        .SPW        (SPW)
    ) bus ();

    pc_call_stack #(
        .WIDTH      (WIDTH),
        .STACK_DEPTH(STACK_DEPTH),
        .SPW        (SPW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // One stimulus record: controls, target, expected state after the edge
    typedef struct {
        logic        rs;
        logic        rt;
        logic        cl;
        logic        ld;
        logic        ic;
        logic [15:0] din;
        logic [15:0] e_out;
        logic [3:0]  e_depth;
        logic        e_err_p;   // expected err, pulse mode
        logic        e_err_s;   // expected err, sticky mode
    } vec_t;

    // Scoreboard entry
    typedef struct {
        logic [15:0] out;
        logic [3:0]  depth;
        logic        err;
        int          idx;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rs, input logic rt, input logic cl,
                                input logic ld, input logic ic, input logic [15:0] din,
                                input logic [15:0] e_out, input logic [3:0] e_depth,
                                input logic e_err_p, input logic e_err_s);
        vec_t v;
        v.rs = rs; v.rt = rt; v.cl = cl; v.ld = ld; v.ic = ic; v.din = din;
        v.e_out = e_out; v.e_depth = e_depth; v.e_err_p = e_err_p; v.e_err_s = e_err_s;
        return v;
    endfunction

    task automatic drive_idle();
        bus.reset = 1'b0;
        bus.ret   = 1'b0;
        bus.call  = 1'b0;
        bus.load  = 1'b0;
        bus.inc   = 1'b0;
        bus.in    = '0;
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs
    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty when output was due");
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d out", e.idx),   32'(bus.out),   32'(e.out));
            check($sformatf("v%0d depth", e.idx), 32'(bus.depth), 32'(e.depth));
            check($sformatf("v%0d err", e.idx),   32'(bus.err),   32'(e.err));
            check($sformatf("v%0d full", e.idx),  32'(bus.full),  32'(e.depth == 4'd8));
            check($sformatf("v%0d empty", e.idx), 32'(bus.empty), 32'(e.depth == 4'd0));
        end
    endtask

    // Drive one record on the falling edge, queue its expectation, and
    // compare after the rising edge
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        bus.reset = v.rs;
        bus.ret   = v.rt;
        bus.call  = v.cl;
        bus.load  = v.ld;
        bus.inc   = v.ic;
        bus.in    = v.din;
        e.out   = v.e_out;
        e.depth = v.e_depth;
        e.err   = STICKY ? v.e_err_s : v.e_err_p;
        e.idx   = idx;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        drive_idle();

        // Reset state while rst_n is held low
        #12;
        check("rst out",   32'(bus.out),   32'h0);
        check("rst depth", 32'(bus.depth), 32'h0);
        check("rst empty", 32'(bus.empty), 32'h1);
        check("rst full",  32'(bus.full),  32'h0);
        check("rst err",   32'(bus.err),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-count: load 5, then drop rst_n between edges
        apply(mk(0,0,0,1,0, 16'h0005, 16'h0005, 4'd0, 0, 0), -1);
        apply(mk(0,0,1,0,0, 16'h0033, 16'h0033, 4'd1, 0, 0), -2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out",   32'(bus.out),   32'h0);
        check("async depth", 32'(bus.depth), 32'h0);
        check("async empty", 32'(bus.empty), 32'h1);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Load, increment and wrap
        vecs.push_back(mk(0,0,0,1,0, 16'h0100, 16'h0100, 4'd0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1, 16'h0000, 16'h0101, 4'd0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1, 16'h0000, 16'h0102, 4'd0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1, 16'h0000, 16'h0103, 4'd0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0, 16'hFFFF, 16'hFFFF, 4'd0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1, 16'h0000, 16'h0000, 4'd0, 0, 0));
        // Call then ret returns PC+1 of the caller
        vecs.push_back(mk(0,0,0,1,0, 16'h0010, 16'h0010, 4'd0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 16'h0200, 16'h0200, 4'd1, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h0011, 4'd0, 0, 0));
        // Underflow: ret on empty stack, then err behaviour over later cycles
        vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h0011, 4'd0, 1, 1));
        vecs.push_back(mk(0,0,0,0,0, 16'h0000, 16'h0011, 4'd0, 0, 1));
        vecs.push_back(mk(0,0,0,0,1, 16'h0000, 16'h0012, 4'd0, 0, 1));
        vecs.push_back(mk(1,0,0,0,0, 16'h0000, 16'h0000, 4'd0, 0, 0));
        // Fill the stack with eight calls
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0,0,1,0,0, 16'h1000 + 16'(k), 16'h1000 + 16'(k),
                              4'(k + 1), 0, 0));
        end
        // Overflow: ninth call is refused
        vecs.push_back(mk(0,0,1,0,0, 16'h0300, 16'h1007, 4'd8, 1, 1));
        vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h1007, 4'd7, 0, 1));
        vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h1006, 4'd6, 0, 1));
        // Priority: reset beats ret and load
        vecs.push_back(mk(1,1,0,1,0, 16'hABCD, 16'h0000, 4'd0, 0, 0));
        // Priority: ret beats call and inc
        vecs.push_back(mk(0,0,1,0,0, 16'h0040, 16'h0040, 4'd1, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 16'h0050, 16'h0050, 4'd2, 0, 0));
        vecs.push_back(mk(0,1,1,0,1, 16'h0777, 16'h0041, 4'd1, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h0001, 4'd0, 0, 0));
        // Priority: call beats load, load beats inc
        vecs.push_back(mk(0,0,1,1,0, 16'h0123, 16'h0123, 4'd1, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, 16'h0555, 16'h0555, 4'd1, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 16'h0000, 16'h0002, 4'd0, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i], i);
        end

        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_call_stack
